lc_runtime_cfg: RTL and testbench

- Runtime-reconfigurable iCE40-style logic cell: a 4-input LUT, a carry generator and an output flop.
- The cell's configuration word is written serially over a valid/ready stream instead of being fixed by parameters.
- A configuration writer FSM assembles the word into a shadow register and commits it atomically to the active configuration only after a complete, correctly sized frame.
- Used on the FPGA as a field-patchable glue-logic cell and as the writer-side bench companion for the fixed logic-cell simulation model.

---
 rtl/lc_cfg_pkg.sv | 30 +++
 rtl/lc_runtime_cfg_if.sv | 30 +++
 rtl/lc_cfg_writer.sv | 76 +++++++
 rtl/lc_runtime_cfg.sv | 71 +++++++
 tb/tb_lc_runtime_cfg.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc_cfg_pkg.sv
// Shared types for the runtime-configurable logic cell:
// frame layout, active-config struct and writer FSM states.
package lc_cfg_pkg;

    localparam int CFG_BITS        = 20;
    localparam int CNT_W           = $clog2(CFG_BITS + 1);
    localparam int LUT_MSB         = 19;
    localparam int LUT_LSB         = 4;
    localparam int CARRY_EN_BIT    = 3;
    localparam int DFF_EN_BIT      = 2;
    localparam int SET_NORESET_BIT = 1;
    localparam int ASYNC_SR_BIT    = 0;

    typedef struct packed {
        logic [15:0] lut;
        logic        carry_en;
        logic        dff_en;
        logic        set_noreset;
        logic        async_sr;
    } lc_cfg_t;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        DRAIN,
        COMMIT,
        ERR
    } wr_state_e;

endpackage

// File: rtl/lc_runtime_cfg_if.sv
// Serial configuration stream: one bit per valid/ready beat,
// plus commit/discard status pulses back to the writer side.
interface lc_runtime_cfg_if;

    logic cfg_valid;
    logic cfg_bit;
    logic cfg_last;
    logic cfg_ready;
    logic cfg_done;
    logic cfg_err;

    modport master (
        output cfg_valid,
        output cfg_bit,
        output cfg_last,
        input  cfg_ready,
        input  cfg_done,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_bit,
        input  cfg_last,
        output cfg_ready,
        output cfg_done,
        output cfg_err
    );

endinterface

// File: rtl/lc_cfg_writer.sv
// Config writer: shifts a serial frame into a shadow register
// and strobes commit only for a complete, correctly sized frame.
module lc_cfg_writer
    import lc_cfg_pkg::*;
(
    input  logic            CLK,
    input  logic            RESETN,
    lc_runtime_cfg_if.slave cfg,
    output lc_cfg_t         cfg_o,
    output logic            commit_o
);

    wr_state_e           state_q, state_d;
    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_inc;
    logic                accept;
    logic                full;

    assign accept  = cfg.cfg_valid && cfg.cfg_ready;
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign full    = (cnt_inc == CNT_W'(CFG_BITS));

    // IDLE sees cnt=0, so it shares the SHIFT decision logic
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE, SHIFT: begin
                if (accept) begin
                    shadow_d = {shadow_q[CFG_BITS-2:0], cfg.cfg_bit};
                    if (!full) cnt_d = cnt_inc;
                    if (full)
                        state_d = cfg.cfg_last ? COMMIT : DRAIN;
                    else
                        state_d = cfg.cfg_last ? ERR : SHIFT;
                end
            end
            DRAIN: begin
                if (accept && cfg.cfg_last) state_d = ERR;
            end
            COMMIT, ERR: begin
                state_d  = IDLE;
                shadow_d = '0;
                cnt_d    = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cfg.cfg_ready = RESETN &&
        (state_q inside {IDLE, SHIFT, DRAIN});
    assign cfg.cfg_done  = (state_q == COMMIT);
    assign cfg.cfg_err   = (state_q == ERR);
    assign commit_o      = (state_q == COMMIT);

    assign cfg_o.lut         = shadow_q[LUT_MSB:LUT_LSB];
    assign cfg_o.carry_en    = shadow_q[CARRY_EN_BIT];
    assign cfg_o.dff_en      = shadow_q[DFF_EN_BIT];
    assign cfg_o.set_noreset = shadow_q[SET_NORESET_BIT];
    assign cfg_o.async_sr    = shadow_q[ASYNC_SR_BIT];

endmodule

// File: rtl/lc_runtime_cfg.sv
// Runtime-reconfigurable logic cell: 4-LUT, carry and output
// flop, driven by an atomically committed active configuration.
module lc_runtime_cfg
    import lc_cfg_pkg::*;
#(
    parameter logic [15:0] RESET_LUT = 16'h0000
) (
    input  logic            CLK,
    input  logic            RESETN,
    lc_runtime_cfg_if.slave cfg,
    input  logic            I0,
    input  logic            I1,
    input  logic            I2,
    input  logic            I3,
    input  logic            CIN,
    input  logic            CEN,
    input  logic            SR,
    output logic            LO,
    output logic            O,
    output logic            COUT
);

    lc_cfg_t    act_q, act_d;
    lc_cfg_t    new_cfg;
    logic       commit;
    logic [3:0] lut_idx;
    logic       q_q, q_d;
    logic       sr_set;
    logic       q_vis;

    lc_cfg_writer u_writer (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .cfg      (cfg),
        .cfg_o    (new_cfg),
        .commit_o (commit)
    );

    always_comb begin
        act_d = act_q;
        if (commit) act_d = new_cfg;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) act_q <= {RESET_LUT, 4'b0000};
        else         act_q <= act_d;
    end

    assign lut_idx = {I3, I2, I1, I0};
    assign LO      = act_q.lut[lut_idx];
    assign COUT    = act_q.carry_en &
        ((I1 & I2) | ((I1 | I2) & CIN));

    assign sr_set = act_q.async_sr & SR;

    always_comb begin
        q_d = q_q;
        if (CEN) q_d = SR ? act_q.set_noreset : LO;
    end

    // async set is its own event; RESETN stays separate and wins
    always_ff @(posedge CLK or negedge RESETN or posedge sr_set) begin
        if (!RESETN)     q_q <= 1'b0;
        else if (sr_set) q_q <= act_q.set_noreset;
        else             q_q <= q_d;
    end

    assign q_vis = RESETN & (sr_set ? act_q.set_noreset : q_q);
    assign O     = act_q.dff_en ? q_vis : LO;

endmodule

// File: tb/tb_lc_runtime_cfg.sv
// Scoreboard bench for lc_runtime_cfg: random frames and cell
// inputs checked against a behavioural model of the cell.
module tb_lc_runtime_cfg;

    logic CLK = 1'b0;
    logic RESETN = 1'b0;
    logic I0 = 1'b0, I1 = 1'b0, I2 = 1'b0, I3 = 1'b0;
    logic CIN = 1'b0, CEN = 1'b0, SR = 1'b0;
    logic LO, O, COUT;

    lc_runtime_cfg_if cfg ();

    lc_runtime_cfg #(.RESET_LUT(16'h0000)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .cfg    (cfg),
        .I0     (I0),
        .I1     (I1),
        .I2     (I2),
        .I3     (I3),
        .CIN    (CIN),
        .CEN    (CEN),
        .SR     (SR),
        .LO     (LO),
        .O      (O),
        .COUT   (COUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit        is_done;
        bit [15:0] lut;
        bit        c, d, s, a;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    bit [15:0] m_lut = 16'h0000;
    bit        m_c = 0, m_d = 0, m_s = 0, m_a = 0;
    bit        mq = 0;
    bit        pend = 0;
    exp_t      pend_e;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (RESETN && (cfg.cfg_done === 1'b1 || cfg.cfg_err === 1'b1)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame_resp: unexpected done=%b err=%b",
                         cfg.cfg_done, cfg.cfg_err);
            end else begin
                e = exp_q.pop_front();
                if (cfg.cfg_done !== e.is_done || cfg.cfg_err !== !e.is_done) begin
                    errors++;
                    $display("FAIL frame_resp: got done=%b err=%b expected done=%b err=%b",
                             cfg.cfg_done, cfg.cfg_err, e.is_done, !e.is_done);
                end
                if (e.is_done) begin
                    pend   = 1;
                    pend_e = e;
                end
            end
        end
    end

    always @(posedge CLK) begin
        if (RESETN) begin
            if (m_a && SR)  mq = m_s;
            else if (CEN)   mq = SR ? m_s : m_lut[{I3, I2, I1, I0}];
            if (pend) begin
                m_lut = pend_e.lut;
                m_c   = pend_e.c;
                m_d   = pend_e.d;
                m_s   = pend_e.s;
                m_a   = pend_e.a;
                pend  = 0;
            end
        end
    end

    always @(negedge RESETN) begin
        m_lut = 16'h0000;
        {m_c, m_d, m_s, m_a} = 4'b0000;
        mq   = 0;
        pend = 0;
    end

    always @(posedge SR) if (RESETN && m_a) mq = m_s;

    task automatic check_cell(input string tag);
        bit [3:0] idx;
        bit       elo, ecout, eo;
        idx   = {I3, I2, I1, I0};
        elo   = m_lut[idx];
        ecout = m_c && ((int'(I1) + int'(I2) + int'(CIN)) >= 2);
        eo    = m_d ? ((m_a && SR) ? m_s : mq) : elo;
        chk({tag, "_LO"}, LO, elo);
        chk({tag, "_O"}, O, eo);
        chk({tag, "_COUT"}, COUT, ecout);
    endtask

    task automatic set_in(input bit [3:0] v);
        {I3, I2, I1, I0} = v;
    endtask

    task automatic send_bit(input bit b, input bit l);
        int n = 0;
        while (cfg.cfg_ready !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (cfg.cfg_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: cfg_ready=%b after %0d cycles, expected 1",
                     cfg.cfg_ready, n);
        end
        cfg.cfg_valid = 1'b1;
        cfg.cfg_bit   = b;
        cfg.cfg_last  = l;
        @(negedge CLK);
        cfg.cfg_valid = 1'b0;
        cfg.cfg_bit   = 1'b0;
        cfg.cfg_last  = 1'b0;
    endtask

    task automatic send_frame(input int len, input bit [63:0] data);
        exp_t e;
        for (int i = len - 1; i >= 0; i--) begin
            if ($urandom_range(3) == 0) @(negedge CLK);
            set_in(4'($urandom));
            CIN = 1'($urandom);
            #1;
            check_cell("partial");
            if (i == 0) begin
                e.is_done = (len == 20);
                e.lut     = data[19:4];
                e.c       = data[3];
                e.d       = data[2];
                e.s       = data[1];
                e.a       = data[0];
                exp_q.push_back(e);
            end
            send_bit(data[i], i == 0);
        end
        check_cell("commit_cycle");
    endtask

    task automatic wait_resp(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d responses pending, expected 0",
                     tag, exp_q.size());
            exp_q.delete();
        end
        @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit [63:0] fr;
        int        len;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_bit   = 1'b0;
        cfg.cfg_last  = 1'b0;
        set_in(4'hF);
        #12;
        chk("rst_ready", cfg.cfg_ready, 1'b0);
        chk("rst_done", cfg.cfg_done, 1'b0);
        chk("rst_err", cfg.cfg_err, 1'b0);
        check_cell("rst");
        chk("rst_LO_const", LO, 1'b0);
        @(negedge CLK);
        RESETN = 1'b1;
        #1;
        chk("ready_after_rst", cfg.cfg_ready, 1'b1);
        @(negedge CLK);

        fr = {44'd0, 16'h8000, 4'b0000};
        send_frame(20, fr);
        wait_resp("and4");
        set_in(4'hF);
        #1;
        check_cell("and4_F");
        chk("and4_F_O_const", O, 1'b1);
        set_in(4'hE);
        #1;
        check_cell("and4_E");
        chk("and4_E_LO_const", LO, 1'b0);
        @(negedge CLK);

        send_frame(19, {32'($urandom), 32'($urandom)});
        wait_resp("short");
        set_in(4'hF);
        #1;
        chk("short_keep_LO", LO, 1'b1);
        check_cell("short");
        @(negedge CLK);

        send_frame(25, {32'($urandom), 32'($urandom)});
        wait_resp("long");
        set_in(4'hF);
        #1;
        chk("long_keep_LO", LO, 1'b1);
        check_cell("long");
        @(negedge CLK);

        fr = {44'd0, 16'hAAAA, 4'b0111};
        send_frame(20, fr);
        wait_resp("async");
        set_in(4'h0);
        CEN = 1'b1;
        @(negedge CLK);
        chk("async_cap0", O, 1'b0);
        check_cell("async_cap0");
        CEN = 1'b0;
        #2 SR = 1'b1;
        #1;
        chk("async_sr_force", O, 1'b1);
        check_cell("async_sr_force");
        SR = 1'b0;
        #1;
        chk("async_sr_hold", O, 1'b1);
        @(negedge CLK);
        CEN = 1'b1;
        @(negedge CLK);
        chk("async_recap0", O, 1'b0);
        CEN = 1'b0;
        #1 SR = 1'b1;
        #1;
        chk("async_sr_cen0", O, 1'b1);
        SR = 1'b0;
        @(negedge CLK);

        fr = {44'd0, 16'hAAAA, 4'b0110};
        send_frame(20, fr);
        wait_resp("sync");
        #1 check_cell("sync_keep_q");
        set_in(4'h0);
        SR = 1'b1;
        #1;
        check_cell("sync_sr_no_edge");
        @(negedge CLK);
        chk("sync_sr_cen0", O, 1'b1);
        CEN = 1'b1;
        SR  = 1'b0;
        @(negedge CLK);
        chk("sync_cap0", O, 1'b0);
        SR = 1'b1;
        @(negedge CLK);
        chk("sync_set", O, 1'b1);
        check_cell("sync_set");
        SR  = 1'b0;
        CEN = 1'b0;

        fr = {44'd0, 16'h0000, 4'b1000};
        send_frame(20, fr);
        wait_resp("carry");
        set_in(4'b0010);
        CIN = 1'b1;
        #1;
        chk("carry_cin1", COUT, 1'b1);
        check_cell("carry_cin1");
        CIN = 1'b0;
        #1;
        chk("carry_cin0", COUT, 1'b0);
        @(negedge CLK);

        for (int i = 0; i < 10; i++) send_bit(1'($urandom), 1'b0);
        set_in(4'b0010);
        CIN = 1'b1;
        #1;
        chk("midframe_cout", COUT, 1'b1);
        RESETN = 1'b0;
        #1;
        chk("rst_cout_drop", COUT, 1'b0);
        chk("rst_mid_ready", cfg.cfg_ready, 1'b0);
        check_cell("rst_mid");
        @(negedge CLK);
        RESETN = 1'b1;
        repeat (3) @(negedge CLK);
        chk("post_rst_ready", cfg.cfg_ready, 1'b1);
        check_cell("post_rst");

        for (int it = 0; it < 10; it++) begin
            SR  = 1'b0;
            len = ($urandom_range(3) == 0) ? int'($urandom_range(1, 30)) : 20;
            send_frame(len, {32'($urandom), 32'($urandom)});
            wait_resp("rand");
            for (int c = 0; c < 12; c++) begin
                set_in(4'($urandom));
                CIN = 1'($urandom);
                CEN = 1'($urandom);
                SR  = ($urandom_range(3) == 0);
                #1;
                check_cell("rand");
                @(negedge CLK);
            end
        end
        SR = 1'b0;

        repeat (3) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
